// File: rtl/qs_pkg.sv
// Shared types for the sort-queue dequeue side: bank status/state, word and
// address types, and the dequeue FSM encoding.
package qs_pkg;

  localparam int BANKS_N   = 4;
  localparam int N         = 8;
  localparam int W         = 8;
  localparam int ADDR_W    = $clog2(N);
  localparam int N_W       = $clog2(N + 1);
  localparam int BANK_ID_W = $clog2(BANKS_N);

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [W-1:0]         w_t;
  typedef logic [N_W-1:0]       n_t;
  typedef logic [BANK_ID_W-1:0] bank_id_t;

  typedef enum logic [2:0] {
    BANK_IDLE      = 3'd0,
    BANK_LOADING   = 3'd1,
    BANK_SORTING   = 3'd2,
    BANK_READY     = 3'd3,
    BANK_UNLOADING = 3'd4
  } bank_status_t;

  typedef struct packed {
    bank_status_t status;
    n_t           n;
  } bank_state_t;

  typedef enum logic [2:0] {
    DEQ_IDLE    = 3'd0,
    DEQ_CLAIM   = 3'd1,
    DEQ_STREAM  = 3'd2,
    DEQ_DRAIN   = 3'd3,
    DEQ_RELEASE = 3'd4
  } deq_state_t;

  // Round-robin successor; 0 follows BANKS_N-1.
  function automatic bank_id_t next_bank(input bank_id_t b);
    if (b == bank_id_t'(BANKS_N - 1)) return '0;
    return b + bank_id_t'(1);
  endfunction

endpackage

// File: rtl/qs_deq_fifo.sv
// Output buffer for the dequeue controller: DEPTH-entry synchronous FIFO.
// Head entry is presented on dout whenever cnt is non-zero.
module qs_deq_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DW-1:0]                din,
  input  logic                         pop,
  output logic [DW-1:0]                dout,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  localparam ptr_t LAST_PTR  = ptr_t'(DEPTH - 1);
  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t CNT_DEPTH = cnt_t'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          rd_ptr_q, rd_ptr_d;
  cnt_t          cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = mem_q[rd_ptr_q];
  assign cnt  = cnt_q;

  // The upstream credit scheme must never push into a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (cnt_q == CNT_DEPTH)));

endmodule

// File: rtl/qs_deq.sv
// Dequeue controller for the sort queue. Claims READY banks in round-robin
// order, streams their words out over out_vld/out_rdy with out_last on the
// final word, then returns the bank to IDLE.
//
// Handshake: a word transfers in every cycle where out_vld && out_rdy; while
// out_vld && !out_rdy the presented word and out_last hold stable.
//
// Credits: a credit is taken when a read is scheduled (one cycle before
// deq_rd_en_r) and returned when its word leaves the buffer, so scheduled +
// in-flight + buffered never exceeds DEPTH.
//
// Optional: define QS_DEQ_STATS_EN to add deq_words_cnt_r, a free-running
// count of accepted output words.
module qs_deq
  import qs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output bank_id_t    deq_bank_idx_r,
  output logic        deq_bank_in_vld,
  output bank_state_t deq_bank_in,
  input  bank_state_t deq_bank_out,
  output logic        deq_rd_en_r,
  output addr_t       deq_rd_addr_r,
  input  logic        deq_rd_data_vld_r,
  input  w_t          deq_rd_data_r,
  output logic        out_vld,
  output w_t          out_w,
  output logic        out_last,
  input  logic        out_rdy,
  output logic        busy_r,
  output deq_state_t  dbg_state
`ifdef QS_DEQ_STATS_EN
  ,
  output logic [31:0] deq_words_cnt_r
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t CNT_DEPTH = cnt_t'(DEPTH);
  localparam n_t   N_ONE     = n_t'(1);

  deq_state_t  state_q, state_d;
  bank_id_t    idx_q, idx_d;
  logic        bank_in_vld_q, bank_in_vld_d;
  bank_state_t bank_in_q, bank_in_d;
  logic        rd_en_q, rd_en_d;
  addr_t       rd_addr_q, rd_addr_d;
  logic        rd_last_q, rd_last_d;
  logic        last_p1_q, last_p1_d;
  logic        last_p2_q, last_p2_d;
  n_t          n_q, n_d;
  n_t          rp_q, rp_d;
  cnt_t        cred_q, cred_d;
  logic        busy_q, busy_d;

  logic        issue;
  logic        pop;
  logic        can_issue;
  logic        drain_done;
  cnt_t        fifo_cnt;
  logic [W:0]  fifo_dout;

  qs_deq_fifo #(.DEPTH(DEPTH), .DW(W + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (deq_rd_data_vld_r),
    .din   ({last_p2_q, deq_rd_data_r}),
    .pop   (pop),
    .dout  (fifo_dout),
    .cnt   (fifo_cnt)
  );

  assign out_vld  = (fifo_cnt != '0);
  assign out_w    = fifo_dout[W-1:0];
  assign out_last = out_vld & fifo_dout[W];
  assign pop      = out_vld & out_rdy;

  assign can_issue  = (cred_q < CNT_DEPTH) || ((cred_q == CNT_DEPTH) && pop);
  // Nothing scheduled or in flight, and the buffer empties this cycle.
  assign drain_done = (cred_q == fifo_cnt) &&
                      ((fifo_cnt == '0) || ((fifo_cnt == CNT_ONE) && pop));

  // FSM next state, bank-port and read-port outputs.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bank_in_vld_d = 1'b0;
    bank_in_d     = bank_in_q;
    rd_en_d       = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_last_d     = 1'b0;
    n_d           = n_q;
    rp_d          = rp_q;
    issue         = 1'b0;
    case (state_q)
      DEQ_IDLE: begin
        if (deq_bank_out.status == BANK_READY) begin
          state_d          = DEQ_CLAIM;
          bank_in_vld_d    = 1'b1;
          bank_in_d        = deq_bank_out;
          bank_in_d.status = BANK_UNLOADING;
          n_d              = deq_bank_out.n;
        end
      end
      DEQ_CLAIM: begin
        rp_d = '0;
        if (n_q == '0) begin
          state_d          = DEQ_RELEASE;
          bank_in_vld_d    = 1'b1;
          bank_in_d.status = BANK_IDLE;
          bank_in_d.n      = '0;
        end else begin
          // The buffer is empty here, so address 0 is scheduled right away.
          issue     = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          rd_last_d = (n_q == N_ONE);
          rp_d      = N_ONE;
          state_d   = (n_q == N_ONE) ? DEQ_DRAIN : DEQ_STREAM;
        end
      end
      DEQ_STREAM: begin
        if (can_issue) begin
          issue     = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = addr_t'(rp_q);
          rd_last_d = (rp_q == n_q - N_ONE);
          rp_d      = rp_q + N_ONE;
          if (rp_q == n_q - N_ONE) state_d = DEQ_DRAIN;
        end
      end
      DEQ_DRAIN: begin
        if (drain_done) begin
          state_d          = DEQ_RELEASE;
          bank_in_vld_d    = 1'b1;
          bank_in_d.status = BANK_IDLE;
          bank_in_d.n      = '0;
        end
      end
      DEQ_RELEASE: begin
        idx_d   = next_bank(idx_q);
        state_d = DEQ_IDLE;
      end
      default: state_d = DEQ_IDLE;
    endcase
  end

  // Credit count, last-flag pipeline aligned to read latency, busy flag.
  always_comb begin
    cred_d = cred_q;
    if (issue && !pop)      cred_d = cred_q + CNT_ONE;
    else if (!issue && pop) cred_d = cred_q - CNT_ONE;
    last_p1_d = rd_en_q & rd_last_q;
    last_p2_d = last_p1_q;
    busy_d    = (state_d != DEQ_IDLE);
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= DEQ_IDLE;
      idx_q         <= '0;
      bank_in_vld_q <= 1'b0;
      bank_in_q     <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      rd_last_q     <= 1'b0;
      last_p1_q     <= 1'b0;
      last_p2_q     <= 1'b0;
      n_q           <= '0;
      rp_q          <= '0;
      cred_q        <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      bank_in_vld_q <= bank_in_vld_d;
      bank_in_q     <= bank_in_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      rd_last_q     <= rd_last_d;
      last_p1_q     <= last_p1_d;
      last_p2_q     <= last_p2_d;
      n_q           <= n_d;
      rp_q          <= rp_d;
      cred_q        <= cred_d;
      busy_q        <= busy_d;
    end
  end

  assign deq_bank_idx_r  = idx_q;
  assign deq_bank_in_vld = bank_in_vld_q;
  assign deq_bank_in     = bank_in_q;
  assign deq_rd_en_r     = rd_en_q;
  assign deq_rd_addr_r   = rd_addr_q;
  assign busy_r          = busy_q;
  assign dbg_state       = state_q;

`ifdef QS_DEQ_STATS_EN
  logic [31:0] words_q, words_d;

  // Accepted-word counter, wraps at 2^32.
  always_comb begin
    words_d = words_q;
    if (pop) words_d = words_q + 32'd1;
  end

  // Accepted-word counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) words_q <= '0;
    else        words_q <= words_d;
  end

  assign deq_words_cnt_r = words_q;
`endif

endmodule

// File: tb/tb_qs_deq.sv
// Bench for qs_deq: behavioural bank array (state + 2-cycle read), expected
// word queue built from the loaded bank contents in round-robin order.
module tb_qs_deq;
  import qs_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bank_id_t    deq_bank_idx_r;
  logic        deq_bank_in_vld;
  bank_state_t deq_bank_in;
  bank_state_t deq_bank_out;
  logic        deq_rd_en_r;
  addr_t       deq_rd_addr_r;
  logic        deq_rd_data_vld_r;
  w_t          deq_rd_data_r;
  logic        out_vld;
  w_t          out_w;
  logic        out_last;
  logic        out_rdy;
  logic        busy_r;
  deq_state_t  dbg_state;
`ifdef QS_DEQ_STATS_EN
  logic [31:0] deq_words_cnt_r;
`endif

  qs_deq #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .deq_bank_idx_r    (deq_bank_idx_r),
    .deq_bank_in_vld   (deq_bank_in_vld),
    .deq_bank_in       (deq_bank_in),
    .deq_bank_out      (deq_bank_out),
    .deq_rd_en_r       (deq_rd_en_r),
    .deq_rd_addr_r     (deq_rd_addr_r),
    .deq_rd_data_vld_r (deq_rd_data_vld_r),
    .deq_rd_data_r     (deq_rd_data_r),
    .out_vld           (out_vld),
    .out_w             (out_w),
    .out_last          (out_last),
    .out_rdy           (out_rdy),
    .busy_r            (busy_r),
    .dbg_state         (dbg_state)
`ifdef QS_DEQ_STATS_EN
    ,
    .deq_words_cnt_r   (deq_words_cnt_r)
`endif
  );

  // ---------------- check / scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [W:0] exp_q[$];
  int         claim_q[$];

  // ---------------- bank array model ----------------
  bank_state_t          bank_st [BANKS_N];
  w_t                   bank_mem [BANKS_N][N];
  logic [BANKS_N-1:0]   set_mask = '0;
  n_t                   set_n [BANKS_N];
  logic                 rd_v1, rd_v2;
  w_t                   rd_d1, rd_d2;

  assign deq_bank_out      = bank_st[deq_bank_idx_r];
  assign deq_rd_data_vld_r = rd_v2;
  assign deq_rd_data_r     = rd_d2;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BANKS_N; i++) bank_st[i] <= '{status: BANK_IDLE, n: '0};
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
      rd_d1 <= '0;
      rd_d2 <= '0;
    end else begin
      if (deq_bank_in_vld) bank_st[deq_bank_idx_r] <= deq_bank_in;
      for (int i = 0; i < BANKS_N; i++)
        if (set_mask[i]) bank_st[i] <= '{status: BANK_READY, n: set_n[i]};
      rd_v1 <= deq_rd_en_r;
      rd_d1 <= bank_mem[deq_bank_idx_r][deq_rd_addr_r];
      rd_v2 <= rd_v1;
      rd_d2 <= rd_d1;
    end
  end

  // ---------------- monitor (samples on negedge) ----------------
  int issued = 0, popped = 0, total_acc = 0;
  int rd_evt, acc_evt, vld_evt, rd_seq;
  int first_rd, first_vld, first_acc, last_acc, claim_cyc, rel_cyc;
  logic prev_stall = 1'b0;
  w_t   prev_w;
  logic prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      issued = 0; popped = 0; total_acc = 0; prev_stall = 1'b0;
    end else begin
      chk("credit", 32'((issued - popped) <= DEPTH), 32'd1);
      if (prev_stall) begin
        chk("hold_vld", 32'(out_vld), 32'd1);
        chk("hold_w", 32'(out_w), 32'(prev_w));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_vld) begin
        vld_evt++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) chk("extra_word", 32'd1, 32'd0);
        else chk("word", 32'({out_last, out_w}), 32'(exp_q.pop_front()));
        popped++; acc_evt++; total_acc++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (deq_bank_in_vld) begin
        if (deq_bank_in.status == BANK_UNLOADING) begin
          claim_cyc = cyc;
          rd_seq    = 0;
          claim_q.push_back(int'(deq_bank_idx_r));
          chk("claim_n", 32'(deq_bank_in.n), 32'(bank_st[deq_bank_idx_r].n));
        end else begin
          rel_cyc = cyc;
          chk("release_st", 32'(deq_bank_in), 32'({BANK_IDLE, n_t'(0)}));
        end
      end
      if (deq_rd_en_r) begin
        chk("rd_addr", 32'(deq_rd_addr_r), 32'(rd_seq));
        rd_seq++; issued++; rd_evt++;
        if (first_rd < 0) first_rd = cyc;
      end
      prev_stall = out_vld && !out_rdy;
      prev_w     = out_w;
      prev_last  = out_last;
    end
  end

  // ---------------- driver tasks ----------------
  int model_idx = 0;

  task automatic clear_evts();
    rd_evt = 0; acc_evt = 0; vld_evt = 0; rd_seq = 0;
    first_rd = -1; first_vld = -1; first_acc = -1; last_acc = -1;
    claim_cyc = -1; rel_cyc = -1;
  endtask

  task automatic fill_bank(input int b, input int n);
    for (int i = 0; i < n; i++) bank_mem[b][i] = w_t'($urandom_range(0, (1 << W) - 1));
  endtask

  task automatic push_exp(input int b, input int n);
    logic [W:0] e;
    for (int i = 0; i < n; i++) begin
      e = {1'b0, bank_mem[b][i]};
      if (i == n - 1) e[W] = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic set_ready(input logic [BANKS_N-1:0] mask, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < BANKS_N; i++) set_n[i] = n_t'(n);
    set_mask = mask;
    @(posedge clk); #1;
    set_mask = '0;
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < BANKS_N; i++)
      if (bank_st[i].status != BANK_IDLE) return 1'b0;
    return 1'b1;
  endfunction

  // mode 0: ready high; 1: 1,0,0,1 pattern; 2: low 20 cycles then high; 3: random
  task automatic wait_done(input int mode);
    int k = 0;
    bit done = 1'b0;
    while (!done && k < 800) begin
      case (mode)
        1:       out_rdy = ((k % 4) == 0) || ((k % 4) == 3);
        2: begin
          if (k == 20) chk("stall_reads", 32'(rd_evt), 32'(DEPTH));
          out_rdy = (k >= 20);
        end
        3:       out_rdy = ($urandom_range(0, 3) != 0);
        default: out_rdy = 1'b1;
      endcase
      @(posedge clk); #1;
      k++;
      if (all_idle() && !busy_r) done = 1'b1;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic run_bank(input int n, input int mode, input bit timing, input bit prefilled);
    int b = model_idx;
    if (!prefilled) fill_bank(b, n);
    push_exp(b, n);
    clear_evts();
    out_rdy = (mode != 2);
    set_ready(BANKS_N'(1) << b, n);
    wait_done(mode);
    if (claim_q.size() == 0) chk("claim_missing", 32'd0, 32'd1);
    else chk("claim_idx", 32'(claim_q.pop_front()), 32'(b));
    chk("rd_count", 32'(rd_evt), 32'(n));
    chk("acc_count", 32'(acc_evt), 32'(n));
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("bank_idle", 32'(bank_st[b]), 32'({BANK_IDLE, n_t'(0)}));
    chk("idx_next", 32'(deq_bank_idx_r), 32'((b + 1) % BANKS_N));
    if (n == 0) chk("no_out_vld", 32'(vld_evt), 32'd0);
    if (timing) begin
      if (n == 0) chk("lat_rel0", 32'(rel_cyc - claim_cyc), 32'd1);
      else begin
        chk("lat_rd", 32'(first_rd - claim_cyc), 32'd1);
        chk("lat_vld", 32'(first_vld - claim_cyc), 32'd4);
        chk("stream_rate", 32'(last_acc - first_acc), 32'(n - 1));
        chk("lat_rel", 32'(rel_cyc - claim_cyc), 32'(n + 4));
      end
    end
    model_idx = (b + 1) % BANKS_N;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_idx"}, 32'(deq_bank_idx_r), 32'd0);
    chk({tag, "_bank_in_vld"}, 32'(deq_bank_in_vld), 32'd0);
    chk({tag, "_rd_en"}, 32'(deq_rd_en_r), 32'd0);
    chk({tag, "_rd_addr"}, 32'(deq_rd_addr_r), 32'd0);
    chk({tag, "_out_vld"}, 32'(out_vld), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy_r), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(DEQ_IDLE));
`ifdef QS_DEQ_STATS_EN
    chk({tag, "_words_cnt"}, deq_words_cnt_r, 32'd0);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int to;
    rst_n   = 1'b0;
    out_rdy = 1'b0;
    clear_evts();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Bank 0, fixed words, ready high: latency and one word per cycle.
    bank_mem[0][0] = 8'd5; bank_mem[0][1] = 8'd1;
    bank_mem[0][2] = 8'd9; bank_mem[0][3] = 8'd3;
    run_bank(4, 0, 1'b1, 1'b1);

    // Bank 1, ready toggling 1,0,0,1.
    run_bank(6, 1, 1'b0, 1'b0);

    // Bank 2, empty bank: claim then release only.
    run_bank(0, 0, 1'b1, 1'b0);

    // Bank 3, full bank with a 20-cycle consumer stall.
    run_bank(N, 2, 1'b0, 1'b0);

    // All banks ready with two words each: served 0..BANKS_N-1 then wrap.
    clear_evts();
    for (int b = 0; b < BANKS_N; b++) begin
      fill_bank(b, 2);
      push_exp(b, 2);
    end
    out_rdy = 1'b1;
    set_ready({BANKS_N{1'b1}}, 2);
    wait_done(0);
    for (int b = 0; b < BANKS_N; b++) begin
      if (claim_q.size() == 0) chk("rr_claim_missing", 32'd0, 32'd1);
      else chk("rr_claim_order", 32'(claim_q.pop_front()), 32'(b));
    end
    chk("rr_acc_count", 32'(acc_evt), 32'(2 * BANKS_N));
    chk("rr_exp_left", 32'(exp_q.size()), 32'd0);
    chk("rr_idx_wrap", 32'(deq_bank_idx_r), 32'd0);
    model_idx = 0;

    // Randomized banks with random consumer back-pressure.
    for (int r = 0; r < 8; r++) run_bank($urandom_range(0, N), 3, 1'b0, 1'b0);

`ifdef QS_DEQ_STATS_EN
    chk("words_cnt", deq_words_cnt_r, 32'(total_acc));
`endif

    // Reset in the middle of a stream.
    fill_bank(model_idx, N);
    push_exp(model_idx, N);
    clear_evts();
    out_rdy = 1'b0;
    set_ready(BANKS_N'(1) << model_idx, N);
    to = 0;
    while (rd_evt < 2 && to < 50) begin
      @(posedge clk); #1;
      to++;
    end
    if (rd_evt < 2) chk("midrst_timeout", 32'd0, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    claim_q.delete();
    model_idx = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Recovery after reset starts again at bank 0.
    run_bank(3, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
